// File: rtl/spc_stack_if.sv
// Handshake/bus bundle for the SPC return stack: strobes and data from the
// CPU sequencer in, stack read data and status out.
interface spc_stack_if #(
    parameter int WIDTH  = 19,
    parameter int ADDR_W = 5
);
    logic              state_fetch;
    logic              spcnt;
    logic              spush;
    logic              swp;
    logic              srp;
    logic [WIDTH-1:0]  spcw;
    logic              spcptr_ld;
    logic [ADDR_W-1:0] spcptr_in;
    logic              err_clr;
    logic [WIDTH-1:0]  spco;
    logic [ADDR_W-1:0] spcptr;
    logic [ADDR_W:0]   spdepth;
    logic              spc_full;
    logic              spc_empty;
    logic              spc_ovf;
    logic              spc_unf;

    modport master (
        output state_fetch, spcnt, spush, swp, srp, spcw,
               spcptr_ld, spcptr_in, err_clr,
        input  spco, spcptr, spdepth, spc_full, spc_empty, spc_ovf, spc_unf
    );

    modport slave (
        input  state_fetch, spcnt, spush, swp, srp, spcw,
               spcptr_ld, spcptr_in, err_clr,
        output spco, spcptr, spdepth, spc_full, spc_empty, spc_ovf, spc_unf
    );
endinterface

// File: rtl/spc_stack.sv
// Microcode subroutine return stack (SPC memory + pointer) with occupancy
// tracking, full/empty status and sticky overflow/underflow flags.
module spc_stack #(
    parameter int WIDTH  = 19,
    parameter int ADDR_W = 5,
    parameter int CHECK  = 1
) (
    input  logic        clk,
    input  logic        reset,
    spc_stack_if.slave  bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  ram_q [DEPTH];
    logic [ADDR_W-1:0] spcptr_q, spcptr_d;
    logic [ADDR_W-1:0] spcadr;
    logic [ADDR_W:0]   spdepth_q, spdepth_d;
    logic [WIDTH-1:0]  spco_q, spco_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              counted;
    logic              is_full;
    logic              is_empty;

    always_comb begin
        // Writes for a push land one above the current top, ahead of the pointer bump.
        spcadr    = (bus.spcnt && bus.spush) ? spcptr_q + ADDR_W'(1) : spcptr_q;
        counted   = bus.state_fetch && bus.spcnt && !bus.spcptr_ld;
        is_full   = (spdepth_q == DEPTH_V);
        is_empty  = (spdepth_q == '0);

        spcptr_d  = spcptr_q;
        spdepth_d = spdepth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        spco_d    = spco_q;

        if (bus.srp && !bus.swp) begin
            spco_d = ram_q[spcptr_q];
        end

        if (bus.spcptr_ld) begin
            spcptr_d = bus.spcptr_in;
        end else if (counted && bus.spush) begin
            spcptr_d = spcptr_q + ADDR_W'(1);
            if (!is_full) begin
                spdepth_d = spdepth_q + (ADDR_W + 1)'(1);
            end
        end else if (counted) begin
            spcptr_d = spcptr_q - ADDR_W'(1);
            if (!is_empty) begin
                spdepth_d = spdepth_q - (ADDR_W + 1)'(1);
            end
        end

        // Clear first so a coincident new error still leaves the flag set.
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (CHECK != 0 && counted && bus.spush && is_full) begin
            ovf_d = 1'b1;
        end
        if (CHECK != 0 && counted && !bus.spush && is_empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spcptr_q  <= '0;
            spdepth_q <= '0;
            spco_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            spcptr_q  <= spcptr_d;
            spdepth_q <= spdepth_d;
            spco_q    <= spco_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Stack RAM itself is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && bus.swp) begin
            ram_q[spcadr] <= bus.spcw;
        end
    end

    assign bus.spco      = spco_q;
    assign bus.spcptr    = spcptr_q;
    assign bus.spdepth   = spdepth_q;
    assign bus.spc_full  = is_full;
    assign bus.spc_empty = is_empty;
    assign bus.spc_ovf   = (CHECK != 0) ? ovf_q : 1'b0;
    assign bus.spc_unf   = (CHECK != 0) ? unf_q : 1'b0;
endmodule
